prefetch_resp_queue: RTL and testbench
======================================

// Module: prefetch_resp_queue
// PURPOSE
//  Response-side counterpart of the prefetcher control block. The control block
//  issues prefetch reads on the AXI master AR channel; this block records each
//  issued read, absorbs the in-order read responses, and serves matching slave
//  reads from the stored blocks. It supplies the control block's addrReqHit,
//  almostFull and outstandingReqCnt inputs.
// PARAMETERS
//  ADDR_BITS          64  address width
//  DATA_BITS          512 block/beat width; one R beat carries one block
//  LOG_BLOCK_BYTES    6   low address bits ignored in tag compare
//  LOG_QUEUE_SIZE     3   queue depth = 2**LOG_QUEUE_SIZE entries
//  ALMOST_FULL_MARGIN 1   almostFull when occupancy >= depth - margin
// PORTS
//  clk                in  1              clock
//  resetN             in  1              reset, asynchronous, active-low
//  flushN             in  1              active-low sync flush from control block
//  allocValid         in  1              master AR handshake (masterValid && masterReady)
//  allocAddr          in  ADDR_BITS      address of the issued prefetch read
//  mRvalid            in  1              memory read-response valid
//  mRdata             in  DATA_BITS      memory read-response data
//  mRready            out 1              high while outstandingReqCnt != 0
//  sReqValid          in  1              slave read request valid
//  sReqAddr           in  ADDR_BITS      slave read address
//  sReqReady          out 1              high only in S_IDLE
//  sRvalid            out 1              slave read data valid
//  sRdata             out DATA_BITS      slave read data
//  sRready            in  1              slave read data ready
//  addrReqHit         out 1              comb: accepted request matches head tag
//  addrMiss           out 1              one-cycle pulse: request not served here
//  almostFull         out 1              occupancy >= 2**LOG_QUEUE_SIZE - ALMOST_FULL_MARGIN
//  outstandingReqCnt  out LOG_QUEUE_SIZE+1 pendingCnt + dropCnt
// BEHAVIOUR
//  Reset: all entries INVALID; head=tail=pendPtr=0; counts 0; S_IDLE.
//   Outputs 0 except sReqReady=1. sRdata=0.
//  Entry state: INVALID, PENDING or VALID. An entry holds a tag and a data word.
//   tag = addr bits above LOG_BLOCK_BYTES.
//  Alloc: allocValid && !full writes tag(allocAddr) to tail as PENDING; tail++; pendingCnt++.
//   allocValid while full is dropped. The control block prevents this via almostFull.
//  Response: mRvalid && mRready.
//   - If dropCnt > 0: discard the beat, dropCnt--.
//   - Otherwise: write mRdata to the entry at pendPtr and mark it VALID; pendPtr++; pendingCnt--.
//   - Responses arrive in issue order, single ID.
//  Pointers wrap modulo depth. An extra wrap bit distinguishes full from empty.
//  FSM (slave side):
//   S_IDLE: on sReqValid, the request is accepted.
//    - Non-empty and head tag == tag(sReqAddr): addrReqHit=1.
//      Head VALID: latch data and go to S_RESP. Head PENDING: go to S_WAIT.
//    - Otherwise: addrMiss=1 and the queue is untouched. The top forwards the request to memory.
//   S_WAIT: when the head becomes VALID, latch data and go to S_RESP.
//    - A response written this cycle is visible next cycle, so minimum latency is 1 cycle.
//   S_RESP: sRvalid=1, sRdata stable. On sRready: pop head (head++, entry INVALID) and go to S_IDLE.
//  Latency: request accepted in cycle N with head VALID gives sRvalid in cycle N+1.
//  Flush (flushN=0, sampled at clk):
//   - All entries become INVALID; head=tail=pendPtr=0.
//   - dropCnt += pendingCnt, minus 1 if a response handshake occurs the same cycle; pendingCnt=0.
//   - An allocValid in the flush cycle is applied after the clear and lands at entry 0.
//   - Flush in S_WAIT: go to S_IDLE and pulse addrMiss so the request is re-forwarded.
//   - Flush in S_RESP: the latched beat stays valid until handshake; the pop is suppressed.
//  Simultaneous events:
//   - Alloc + pop in the same cycle: occupancy unchanged.
//   - Response write + head pop in the same cycle are legal.
//   - The counts must never under- or overflow. Violations are assertion failures.
//  Reset mid-operation: immediate return to reset values; in-flight responses are lost.
// STRUCTURE
//  prefetcher_pkg: entry_state_e {INVALID, PENDING, VALID}, rsp_state_e
//   {S_IDLE, S_WAIT, S_RESP}, and a tag-width function.
//  Sub-module prefetch_entry_store: tag/data/state arrays.
//   - One write port for alloc, one for response data, one for invalidate.
//   - Async head read.
//  Top: pointers, counters and FSM.
// TESTING
//  1 Alloc 0x1000, response D0, then slave read 0x1020 (same block):
//    addrReqHit, next cycle sRvalid with sRdata=D0; queue empty after sRready.
//  2 Alloc 0x1000, then slave read 0x1000 before the response:
//    S_WAIT and sReqReady=0; response D1 arrives; next cycle sRvalid with sRdata=D1.
//  3 Fill 8 entries with 7 responses outstanding: almostFull=1 at occupancy 7.
//    A 9th allocValid is ignored; outstandingReqCnt=7.
//  4 3 pending, flushN=0 together with allocValid 0x8000:
//    dropCnt=3 and the next 3 responses are discarded; the 4th lands in the 0x8000 entry.
//  5 Head tag 0x1000, slave read 0x2000: one-cycle addrMiss pulse; head unchanged.
//  6 S_RESP with sRready=0, then flush: sRvalid and sRdata held until sRready; queue empty afterwards.

Source files
------------

// File: rtl/prefetch_resp_queue_pkg.sv
// Shared types and defaults for the prefetch response queue.
// Entry/FSM enums plus the tag-width helper.
package prefetch_resp_queue_pkg;

    localparam int ADDR_BITS_D   = 64;
    localparam int DATA_BITS_D   = 512;
    localparam int LOG_BLOCK_D   = 6;
    localparam int LOG_QUEUE_D   = 3;
    localparam int AF_MARGIN_D   = 1;

    typedef enum logic [1:0] {
        INVALID,
        PENDING,
        VALID
    } entry_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } rsp_state_e;

    function automatic int tag_bits(input int addr_bits, input int log_block);
        return addr_bits - log_block;
    endfunction

endpackage

// File: rtl/prefetch_resp_queue_if.sv
// Handshake bundle between the prefetch control side and the response queue.
// master = control/memory/slave-port side, slave = the queue itself.
interface prefetch_resp_queue_if
    import prefetch_resp_queue_pkg::*;
#(
    parameter int ADDR_BITS      = ADDR_BITS_D,
    parameter int DATA_BITS      = DATA_BITS_D,
    parameter int LOG_QUEUE_SIZE = LOG_QUEUE_D
);

    logic                      allocValid;
    logic [ADDR_BITS-1:0]      allocAddr;
    logic                      mRvalid;
    logic [DATA_BITS-1:0]      mRdata;
    logic                      mRready;
    logic                      sReqValid;
    logic [ADDR_BITS-1:0]      sReqAddr;
    logic                      sReqReady;
    logic                      sRvalid;
    logic [DATA_BITS-1:0]      sRdata;
    logic                      sRready;
    logic                      addrReqHit;
    logic                      addrMiss;
    logic                      almostFull;
    logic [LOG_QUEUE_SIZE:0]   outstandingReqCnt;

    modport master (
        output allocValid, allocAddr, mRvalid, mRdata,
        output sReqValid, sReqAddr, sRready,
        input  mRready, sReqReady, sRvalid, sRdata,
        input  addrReqHit, addrMiss, almostFull, outstandingReqCnt
    );

    modport slave (
        input  allocValid, allocAddr, mRvalid, mRdata,
        input  sReqValid, sReqAddr, sRready,
        output mRready, sReqReady, sRvalid, sRdata,
        output addrReqHit, addrMiss, almostFull, outstandingReqCnt
    );

endinterface

// File: rtl/prefetch_resp_queue_entry_store.sv
// Tag/data/state arrays for the prefetch queue entries.
// Separate alloc, response and invalidate write ports; async head read.
module prefetch_resp_queue_entry_store
    import prefetch_resp_queue_pkg::*;
#(
    parameter int IDX_BITS  = 3,
    parameter int TAG_BITS  = 58,
    parameter int DATA_BITS = 512
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 i_flush,
    input  logic                 i_allocEn,
    input  logic [IDX_BITS-1:0]  i_allocIdx,
    input  logic [TAG_BITS-1:0]  i_allocTag,
    input  logic                 i_rspEn,
    input  logic [IDX_BITS-1:0]  i_rspIdx,
    input  logic [DATA_BITS-1:0] i_rspData,
    input  logic                 i_invEn,
    input  logic [IDX_BITS-1:0]  i_invIdx,
    input  logic [IDX_BITS-1:0]  i_headIdx,
    output logic [TAG_BITS-1:0]  o_headTag,
    output entry_state_e         o_headState,
    output logic [DATA_BITS-1:0] o_headData
);

    localparam int DEPTH = 1 << IDX_BITS;

    entry_state_e         r_state [DEPTH];
    logic [TAG_BITS-1:0]  r_tag   [DEPTH];
    logic [DATA_BITS-1:0] r_data  [DEPTH];

    // Alloc is written last so an alloc in a flush cycle survives the clear.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= INVALID;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_flush)
                    r_state[i] <= INVALID;
                else if (i_rspEn && i_rspIdx == IDX_BITS'(i))
                    r_state[i] <= VALID;
                else if (i_invEn && i_invIdx == IDX_BITS'(i))
                    r_state[i] <= INVALID;
                if (i_allocEn && i_allocIdx == IDX_BITS'(i))
                    r_state[i] <= PENDING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_allocEn) r_tag[i_allocIdx] <= i_allocTag;
        if (i_rspEn)   r_data[i_rspIdx]  <= i_rspData;
    end

    assign o_headTag   = r_tag[i_headIdx];
    assign o_headState = r_state[i_headIdx];
    assign o_headData  = r_data[i_headIdx];

endmodule

// File: rtl/prefetch_resp_queue.sv
// Records issued prefetch reads, absorbs in-order responses and serves
// matching slave reads from the queue head.
module prefetch_resp_queue
    import prefetch_resp_queue_pkg::*;
#(
    parameter int ADDR_BITS          = ADDR_BITS_D,
    parameter int DATA_BITS          = DATA_BITS_D,
    parameter int LOG_BLOCK_BYTES    = LOG_BLOCK_D,
    parameter int LOG_QUEUE_SIZE     = LOG_QUEUE_D,
    parameter int ALMOST_FULL_MARGIN = AF_MARGIN_D
) (
    input logic                clk,
    input logic                resetN,
    input logic                flushN,
    prefetch_resp_queue_if.slave bus
);

    localparam int TAG_BITS = tag_bits(ADDR_BITS, LOG_BLOCK_BYTES);
    localparam int IDX_BITS = LOG_QUEUE_SIZE;
    localparam int CNT_BITS = LOG_QUEUE_SIZE + 1;
    localparam int DEPTH    = 1 << LOG_QUEUE_SIZE;

    rsp_state_e           r_state, w_stateNext;
    logic [CNT_BITS-1:0]  r_head, r_tail, r_pend;
    logic [CNT_BITS-1:0]  r_pendingCnt, r_dropCnt;
    logic [DATA_BITS-1:0] r_sRdata;
    logic                 r_noPop;

    logic                 w_flush, w_full, w_empty;
    logic [CNT_BITS-1:0]  w_occ;
    logic [CNT_BITS:0]    w_outWide;
    logic                 w_rspHs, w_rspDrop, w_rspWr;
    logic                 w_allocOk, w_pop, w_hit, w_miss, w_latch;
    logic [TAG_BITS-1:0]  w_reqTag, w_headTag;
    entry_state_e         w_headState;
    logic [DATA_BITS-1:0] w_headData;
    logic [IDX_BITS-1:0]  w_allocIdx;
    logic                 w_unused;

    assign w_flush   = !flushN;
    assign w_occ     = r_tail - r_head;
    assign w_full    = w_occ == CNT_BITS'(DEPTH);
    assign w_empty   = w_occ == '0;
    assign w_outWide = {1'b0, r_pendingCnt} + {1'b0, r_dropCnt};
    assign w_rspHs   = bus.mRvalid && bus.mRready;
    assign w_rspDrop = w_rspHs && r_dropCnt != '0;
    assign w_rspWr   = w_rspHs && r_dropCnt == '0;
    assign w_allocOk = bus.allocValid && (!w_full || w_flush);
    assign w_allocIdx = w_flush ? '0 : r_tail[IDX_BITS-1:0];
    assign w_reqTag  = bus.sReqAddr[ADDR_BITS-1:LOG_BLOCK_BYTES];
    assign w_unused  = &{1'b0, bus.allocAddr[LOG_BLOCK_BYTES-1:0],
                         bus.sReqAddr[LOG_BLOCK_BYTES-1:0],
                         w_outWide[CNT_BITS]};

    prefetch_resp_queue_entry_store #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS),
        .DATA_BITS(DATA_BITS)
    ) u_store (
        .clk        (clk),
        .resetN     (resetN),
        .i_flush    (w_flush),
        .i_allocEn  (w_allocOk),
        .i_allocIdx (w_allocIdx),
        .i_allocTag (bus.allocAddr[ADDR_BITS-1:LOG_BLOCK_BYTES]),
        .i_rspEn    (w_rspWr && !w_flush),
        .i_rspIdx   (r_pend[IDX_BITS-1:0]),
        .i_rspData  (bus.mRdata),
        .i_invEn    (w_pop),
        .i_invIdx   (r_head[IDX_BITS-1:0]),
        .i_headIdx  (r_head[IDX_BITS-1:0]),
        .o_headTag  (w_headTag),
        .o_headState(w_headState),
        .o_headData (w_headData)
    );

    // A request seen during a flush is treated as a miss and re-forwarded.
    always_comb begin
        w_stateNext = r_state;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_latch     = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.sReqValid) begin
                    if (!w_flush && !w_empty && w_headTag == w_reqTag) begin
                        w_hit = 1'b1;
                        if (w_headState == VALID) begin
                            w_latch     = 1'b1;
                            w_stateNext = S_RESP;
                        end else begin
                            w_stateNext = S_WAIT;
                        end
                    end else begin
                        w_miss = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_flush) begin
                    w_miss      = 1'b1;
                    w_stateNext = S_IDLE;
                end else if (w_headState == VALID) begin
                    w_latch     = 1'b1;
                    w_stateNext = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.sRready) begin
                    w_pop       = !w_flush && !r_noPop;
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_pend       <= '0;
            r_pendingCnt <= '0;
            r_dropCnt    <= '0;
            r_sRdata     <= '0;
            r_noPop      <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_noPop <= (w_stateNext == S_RESP) && (r_state == S_RESP) &&
                       (r_noPop || w_flush);
            if (w_latch) r_sRdata <= w_headData;
            if (w_flush) begin
                r_head       <= '0;
                r_pend       <= '0;
                r_tail       <= CNT_BITS'(w_allocOk);
                r_pendingCnt <= CNT_BITS'(w_allocOk);
                r_dropCnt    <= r_dropCnt + r_pendingCnt - CNT_BITS'(w_rspHs);
            end else begin
                if (w_allocOk) r_tail <= r_tail + CNT_BITS'(1);
                if (w_pop)     r_head <= r_head + CNT_BITS'(1);
                if (w_rspWr)   r_pend <= r_pend + CNT_BITS'(1);
                r_pendingCnt <= r_pendingCnt + CNT_BITS'(w_allocOk)
                                - CNT_BITS'(w_rspWr);
                if (w_rspDrop) r_dropCnt <= r_dropCnt - CNT_BITS'(1);
            end
        end
    end

    assign bus.sReqReady         = r_state == S_IDLE;
    assign bus.sRvalid           = r_state == S_RESP;
    assign bus.sRdata            = r_sRdata;
    assign bus.addrReqHit        = w_hit;
    assign bus.addrMiss          = w_miss;
    assign bus.almostFull        = w_occ >= CNT_BITS'(DEPTH - ALMOST_FULL_MARGIN);
    assign bus.outstandingReqCnt = w_outWide[CNT_BITS-1:0];
    assign bus.mRready           = w_outWide[CNT_BITS-1:0] != '0;

    a_out_no_ovf: assert property (@(posedge clk) disable iff (!resetN)
        !w_outWide[CNT_BITS]);
    a_pend_range: assert property (@(posedge clk) disable iff (!resetN)
        r_pendingCnt <= CNT_BITS'(DEPTH));

endmodule

// File: tb/tb_prefetch_resp_queue.sv
// Bench for prefetch_resp_queue: directed vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_prefetch_resp_queue;

    localparam int AB = 64;
    localparam int DB = 512;
    localparam int LQ = 3;
    localparam logic [63:0] A = 64'h1000;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic flushN = 1'b1;
    int   checks = 0;
    int   errors = 0;

    prefetch_resp_queue_if #(.ADDR_BITS(AB), .DATA_BITS(DB),
                             .LOG_QUEUE_SIZE(LQ)) bus ();

    prefetch_resp_queue dut (
        .clk   (clk),
        .resetN(resetN),
        .flushN(flushN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          a;
        logic [63:0] aa;
        bit          mv;
        int          ds;
        bit          sv;
        logic [63:0] sa;
        bit          sr;
        bit          eh, em, erv, erdy;
        int          eout;
        bit          eaf;
        int          ed;
    } vec_t;

    typedef struct {
        logic [57:0]   tag;
        bit            valid;
        logic [DB-1:0] data;
    } ment_t;

    vec_t          tbl[$];
    logic [DB-1:0] D[5];

    ment_t         mq[$];
    int            mdrop;
    int            mst;
    bit            mnopop;
    logic [DB-1:0] mrdata;

    function automatic logic [DB-1:0] mkdata(input int s);
        logic [DB-1:0] d;
        for (int k = 0; k < 16; k++) d[k*32+:32] = 32'(s * 16 + k) ^ 32'hA5C3_0F00;
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string t, input bit h, input bit m, input bit rv,
                              input bit rdy, input int out, input bit af);
        chk({t, ".hit"},  bus.addrReqHit, h);
        chk({t, ".miss"}, bus.addrMiss, m);
        chk({t, ".rv"},   bus.sRvalid, rv);
        chk({t, ".rdy"},  bus.sReqReady, rdy);
        chk({t, ".out"},  bus.outstandingReqCnt, out);
        chk({t, ".af"},   bus.almostFull, af);
        chk({t, ".mrdy"}, bus.mRready, out != 0);
    endtask

    task automatic clr_in();
        bus.allocValid = 1'b0;
        bus.allocAddr  = '0;
        bus.mRvalid    = 1'b0;
        bus.mRdata     = '0;
        bus.sReqValid  = 1'b0;
        bus.sReqAddr   = '0;
        bus.sRready    = 1'b0;
        flushN         = 1'b1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic do_reset();
        clr_in();
        resetN = 1'b0;
        #1;
        expect_out("rst", 0, 0, 0, 1, 0, 0);
        chkd("rst.data", bus.sRdata, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit a, input logic [63:0] aa, input bit mv, input int ds,
                       input bit sv, input logic [63:0] sa, input bit sr,
                       input bit eh, input bit em, input bit erv, input bit erdy,
                       input int eout, input bit eaf, input int ed);
        vec_t v;
        v = '{a, aa, mv, ds, sv, sa, sr, eh, em, erv, erdy, eout, eaf, ed};
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        mq.delete();
        mdrop  = 0;
        mst    = 0;
        mnopop = 1'b0;
        mrdata = '0;
    endtask

    task automatic run_random(input int cycles);
        logic [DB-1:0] rd;
        logic [63:0]   aa, sa;
        bit            a, mv, sv, sr, fl, rsp, pop, full, hit, miss;
        int            pend, out, nst;
        ment_t         e;
        for (int c = 0; c < cycles; c++) begin
            if (c == cycles / 2) begin
                do_reset();
                model_reset();
            end
            pend = 0;
            foreach (mq[j]) if (!mq[j].valid) pend++;
            out = pend + mdrop;
            a  = ($urandom_range(0, 2) == 0) && out < 15;
            aa = 64'h10000 + 64'($urandom_range(0, 7) << 6) + 64'($urandom_range(0, 63));
            mv = $urandom_range(0, 1) == 1;
            for (int k = 0; k < 16; k++) rd[k*32+:32] = $urandom;
            sv = $urandom_range(0, 1) == 1;
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                sa = {mq[0].tag, 6'($urandom_range(0, 63))};
            else
                sa = 64'h10000 + 64'($urandom_range(0, 7) << 6);
            sr = $urandom_range(0, 2) != 0;
            fl = ($urandom_range(0, 39) == 0) && out <= 7;

            bus.allocValid = a;
            bus.allocAddr  = aa;
            bus.mRvalid    = mv;
            bus.mRdata     = rd;
            bus.sReqValid  = sv;
            bus.sReqAddr   = sa;
            bus.sRready    = sr;
            flushN         = !fl;
            @(negedge clk);

            hit  = mst == 0 && sv && !fl && mq.size() > 0 && mq[0].tag == sa[63:6];
            miss = (mst == 0 && sv && !hit) || (mst == 1 && fl);
            expect_out("rnd", hit, miss, mst == 2, mst == 0, out, mq.size() >= 7);
            if (mst == 2) chkd("rnd.data", bus.sRdata, mrdata);

            rsp = mv && out != 0;
            nst = mst;
            pop = 1'b0;
            case (mst)
                0: if (hit) begin
                    if (mq[0].valid) begin
                        mrdata = mq[0].data;
                        nst = 2;
                    end else nst = 1;
                end
                1: if (fl) nst = 0;
                   else if (mq[0].valid) begin
                       mrdata = mq[0].data;
                       nst = 2;
                   end
                default: if (sr) begin
                    nst = 0;
                    pop = !fl && !mnopop;
                end
            endcase
            mnopop = (mst == 2 && nst == 2) && (mnopop || fl);
            e.tag   = aa[63:6];
            e.valid = 1'b0;
            e.data  = '0;
            if (fl) begin
                mdrop = mdrop + pend - (rsp ? 1 : 0);
                mq.delete();
                if (a) mq.push_back(e);
            end else begin
                full = mq.size() == 8;
                if (rsp) begin
                    if (mdrop > 0) mdrop--;
                    else begin
                        for (int j = 0; j < mq.size(); j++) begin
                            if (!mq[j].valid) begin
                                mq[j].valid = 1'b1;
                                mq[j].data  = rd;
                                break;
                            end
                        end
                    end
                end
                if (pop) void'(mq.pop_front());
                if (a && !full) mq.push_back(e);
            end
            mst = nst;
            next();
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) D[i] = mkdata(i + 1);
        clr_in();
        do_reset();

        // hit after response; wait-for-response; miss leaves head intact
        add(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, -1);
        add(1, A, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, -1);
        add(0, 0, 1, 0, 0, 0, 0,            0, 0, 0, 1, 1, 0, -1);
        add(0, 0, 0, 0, 1, 64'h1020, 0,     1, 0, 0, 1, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 1,            0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, A, 0,            0, 1, 0, 1, 0, 0, -1);
        add(1, A, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, -1);
        add(0, 0, 0, 0, 1, A, 0,            1, 0, 0, 1, 1, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, -1);
        add(0, 0, 1, 1, 0, 0, 0,            0, 0, 0, 0, 1, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 1,            0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, -1);
        add(1, A, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, -1);
        add(0, 0, 1, 2, 0, 0, 0,            0, 0, 0, 1, 1, 0, -1);
        add(0, 0, 0, 0, 1, 64'h2000, 0,     0, 1, 0, 1, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, -1);
        add(0, 0, 0, 0, 1, A, 0,            1, 0, 0, 1, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 1,            0, 0, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 1, A, 0,            0, 1, 0, 1, 0, 0, -1);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.allocValid = tbl[i].a;
            bus.allocAddr  = tbl[i].aa;
            bus.mRvalid    = tbl[i].mv;
            bus.mRdata     = D[tbl[i].ds];
            bus.sReqValid  = tbl[i].sv;
            bus.sReqAddr   = tbl[i].sa;
            bus.sRready    = tbl[i].sr;
            @(negedge clk);
            expect_out($sformatf("vec%0d", i), tbl[i].eh, tbl[i].em, tbl[i].erv,
                       tbl[i].erdy, tbl[i].eout, tbl[i].eaf);
            if (tbl[i].ed >= 0)
                chkd($sformatf("vec%0d.data", i), bus.sRdata, D[tbl[i].ed]);
            next();
        end

        // fill to full, almostFull at 7, ninth alloc dropped
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.allocValid = 1'b1;
            bus.allocAddr  = A + 64'(i * 64);
            @(negedge clk);
            chk($sformatf("fill%0d.out", i), bus.outstandingReqCnt, i);
            chk($sformatf("fill%0d.af", i), bus.almostFull, 1'b0);
            next();
        end
        @(negedge clk);
        expect_out("occ7", 0, 0, 0, 1, 7, 1);
        next();
        bus.allocValid = 1'b1;
        bus.allocAddr  = A + 64'h1c0;
        bus.mRvalid    = 1'b1;
        bus.mRdata     = D[0];
        @(negedge clk);
        expect_out("alloc8", 0, 0, 0, 1, 7, 1);
        next();
        bus.allocValid = 1'b1;
        bus.allocAddr  = 64'h2000;
        @(negedge clk);
        expect_out("alloc9", 0, 0, 0, 1, 7, 1);
        next();
        @(negedge clk);
        expect_out("full", 0, 0, 0, 1, 7, 1);
        next();
        bus.sReqValid = 1'b1;
        bus.sReqAddr  = A;
        @(negedge clk);
        expect_out("full.rd", 1, 0, 0, 1, 7, 1);
        next();
        bus.sRready = 1'b1;
        @(negedge clk);
        chkd("full.data", bus.sRdata, D[0]);
        chk("full.rv", bus.sRvalid, 1'b1);
        next();

        // flush with 3 pending plus alloc in the flush cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.allocValid = 1'b1;
            bus.allocAddr  = A + 64'(i * 64);
            next();
        end
        bus.allocValid = 1'b1;
        bus.allocAddr  = 64'h8000;
        flushN         = 1'b0;
        @(negedge clk);
        expect_out("fl.pre", 0, 0, 0, 1, 3, 0);
        next();
        @(negedge clk);
        expect_out("fl.post", 0, 0, 0, 1, 4, 0);
        next();
        for (int k = 0; k < 3; k++) begin
            bus.mRvalid = 1'b1;
            bus.mRdata  = D[k];
            @(negedge clk);
            chk($sformatf("drop%0d.out", k), bus.outstandingReqCnt, 4 - k);
            next();
        end
        bus.mRvalid = 1'b1;
        bus.mRdata  = D[3];
        @(negedge clk);
        expect_out("fl.land", 0, 0, 0, 1, 1, 0);
        next();
        bus.sReqValid = 1'b1;
        bus.sReqAddr  = 64'h8000;
        @(negedge clk);
        expect_out("fl.rd", 1, 0, 0, 1, 0, 0);
        next();
        bus.sRready = 1'b1;
        @(negedge clk);
        chk("fl.rv", bus.sRvalid, 1'b1);
        chkd("fl.data", bus.sRdata, D[3]);
        next();

        // flush while holding a response with sRready low
        do_reset();
        bus.allocValid = 1'b1;
        bus.allocAddr  = A;
        next();
        bus.mRvalid = 1'b1;
        bus.mRdata  = D[4];
        next();
        bus.sReqValid = 1'b1;
        bus.sReqAddr  = A;
        next();
        for (int k = 0; k < 4; k++) begin
            flushN       = !(k == 1);
            bus.sRready  = k == 3;
            @(negedge clk);
            chk($sformatf("hold%0d.rv", k), bus.sRvalid, 1'b1);
            chkd($sformatf("hold%0d.data", k), bus.sRdata, D[4]);
            next();
        end
        bus.sReqValid = 1'b1;
        bus.sReqAddr  = A;
        @(negedge clk);
        expect_out("hold.after", 0, 1, 0, 1, 0, 0);
        next();

        do_reset();
        model_reset();
        run_random(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
